// File: rtl/bank_cmd_arbiter_pkg.sv
// Shared types and defaults for the DRAM bank command arbiter.
// Holds the command encoding, bus widths, timing defaults and the timer update helper.
package bank_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } cmd_e;

  localparam int ADDR_BITS = 14;
  localparam int BA_BITS   = 3;
  localparam int TMR_BITS  = 4;

  localparam int DEF_T_RCD = 5;
  localparam int DEF_T_RP  = 5;
  localparam int DEF_T_RRD = 4;
  localparam int DEF_T_CCD = 4;
  localparam int DEF_T_WTR = 6;

  typedef logic [TMR_BITS-1:0] tmr_t;

  // A load wins over the decrement; T-1 makes the dependent command eligible T cycles after the grant.
  function automatic tmr_t tmr_next(input tmr_t cur, input logic load, input int t);
    if (load) begin
      return tmr_t'(t - 1);
    end
    if (cur != '0) begin
      return cur - tmr_t'(1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/bank_cmd_arbiter_rr_arbiter.sv
// Round-robin picker: one-hot grant to the first request at or above ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N        = 8,
  parameter int PTR_BITS = 3
) (
  input  logic [N-1:0]        req,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [N-1:0]        grant
);

  logic                found;
  logic [PTR_BITS-1:0] sel;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      sel = PTR_BITS'((int'(ptr) + k) % N);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Shares one DRAM command bus among NUM_BANKS bank FSMs, enforcing
// tRCD/tRP/tRRD/tCCD/tWTR spacing with round-robin fairness.
module bank_cmd_arbiter
  import bank_cmd_arbiter_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int T_RCD     = DEF_T_RCD,
  parameter int T_RP      = DEF_T_RP,
  parameter int T_RRD     = DEF_T_RRD,
  parameter int T_CCD     = DEF_T_CCD,
  parameter int T_WTR     = DEF_T_WTR
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_BANKS-1:0]           bank_req,
  input  logic [2*NUM_BANKS-1:0]         bank_cmd,
  input  logic [ADDR_BITS*NUM_BANKS-1:0] bank_addr,
  input  logic                           refresh_pending,
  output logic [NUM_BANKS-1:0]           bank_stall,
  output logic                           cmd_valid,
  output logic [1:0]                     cmd_type,
  output logic [BA_BITS-1:0]             cmd_bank,
  output logic [ADDR_BITS-1:0]           cmd_addr
);

  cmd_e                 cmd_arr  [NUM_BANKS];
  logic [ADDR_BITS-1:0] addr_arr [NUM_BANKS];

  tmr_t trcd_q [NUM_BANKS];
  tmr_t trcd_d [NUM_BANKS];
  tmr_t trp_q  [NUM_BANKS];
  tmr_t trp_d  [NUM_BANKS];
  tmr_t trrd_q, trrd_d;
  tmr_t tccd_q, tccd_d;
  tmr_t twtr_q, twtr_d;

  logic [BA_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic                 cmd_valid_q, cmd_valid_d;
  cmd_e                 cmd_type_q, cmd_type_d;
  logic [BA_BITS-1:0]   cmd_bank_q, cmd_bank_d;
  logic [ADDR_BITS-1:0] cmd_addr_q, cmd_addr_d;

  logic [NUM_BANKS-1:0] elig;
  logic [NUM_BANKS-1:0] grant;
  logic                 any_grant;
  logic [BA_BITS-1:0]   grant_idx;
  cmd_e                 grant_cmd;

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_unpack
      assign cmd_arr[gi]  = cmd_e'(bank_cmd[2*gi +: 2]);
      assign addr_arr[gi] = bank_addr[ADDR_BITS*gi +: ADDR_BITS];
    end
  endgenerate

  // Refresh only gates ACT so banks can still drain reads/writes and close rows.
  always_comb begin
    elig = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      case (cmd_arr[b])
        CMD_ACT: elig[b] = bank_req[b] && (trp_q[b] == '0) && (trrd_q == '0) && !refresh_pending;
        CMD_RD:  elig[b] = bank_req[b] && (trcd_q[b] == '0) && (tccd_q == '0) && (twtr_q == '0);
        CMD_WR:  elig[b] = bank_req[b] && (trcd_q[b] == '0) && (tccd_q == '0);
        default: elig[b] = bank_req[b];
      endcase
    end
  end

  rr_arbiter #(
    .N        (NUM_BANKS),
    .PTR_BITS (BA_BITS)
  ) u_rr_arbiter (
    .req   (elig),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign bank_stall = ~grant;

  always_comb begin
    any_grant = |grant;
    grant_idx = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (grant[b]) begin
        grant_idx = BA_BITS'(b);
      end
    end
    grant_cmd = cmd_arr[grant_idx];

    for (int b = 0; b < NUM_BANKS; b++) begin
      trcd_d[b] = tmr_next(trcd_q[b], grant[b] && (cmd_arr[b] == CMD_ACT), T_RCD);
      trp_d[b]  = tmr_next(trp_q[b],  grant[b] && (cmd_arr[b] == CMD_PRE), T_RP);
    end
    trrd_d = tmr_next(trrd_q, any_grant && (grant_cmd == CMD_ACT), T_RRD);
    tccd_d = tmr_next(tccd_q, any_grant && ((grant_cmd == CMD_RD) || (grant_cmd == CMD_WR)), T_CCD);
    twtr_d = tmr_next(twtr_q, any_grant && (grant_cmd == CMD_WR), T_WTR);

    rr_ptr_d    = any_grant ? BA_BITS'((int'(grant_idx) + 1) % NUM_BANKS) : rr_ptr_q;
    cmd_valid_d = any_grant;
    cmd_type_d  = any_grant ? grant_cmd          : cmd_type_q;
    cmd_bank_d  = any_grant ? grant_idx          : cmd_bank_q;
    cmd_addr_d  = any_grant ? addr_arr[grant_idx] : cmd_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        trcd_q[b] <= '0;
        trp_q[b]  <= '0;
      end
      trrd_q      <= '0;
      tccd_q      <= '0;
      twtr_q      <= '0;
      rr_ptr_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_ACT;
      cmd_bank_q  <= '0;
      cmd_addr_q  <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        trcd_q[b] <= trcd_d[b];
        trp_q[b]  <= trp_d[b];
      end
      trrd_q      <= trrd_d;
      tccd_q      <= tccd_d;
      twtr_q      <= twtr_d;
      rr_ptr_q    <= rr_ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_addr_q  <= cmd_addr_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_addr  = cmd_addr_q;

endmodule
